// File: rtl/registro_banderas.sv
// registro_banderas: NZCV status register fed by the ALU flag stage.
//  - captures N/Z/C/V per valid ALU op, or takes a direct load (context restore)
//  - evaluates a 4-bit condition code against the next-state flags, result one cycle later
//  - saturating overflow event counter for debug
// Optional: define STICKY_OVF_EN to build the sticky overflow bit; otherwise sticky_v is 0.
module registro_banderas #(
  parameter int          CNT_W     = 8,
  parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flags_valid,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             negative_in,
  input  logic             zero_in,
  input  logic             flags_load,
  input  logic [3:0]       flags_wdata,
  input  logic             cond_req,
  input  logic [3:0]       cond,
  input  logic             ovf_clr,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             cond_valid,
  output logic             cond_true,
  output logic [CNT_W-1:0] ovf_count,
  output logic             sticky_v
);

  logic [3:0]       nzcv_q, nzcv_d;
  logic             cond_hit;
  logic             ovf_evt;
  logic [CNT_W-1:0] cnt_q;

  // Next-state flags; load wins over a normal ALU capture.
  always_comb begin
    nzcv_d = nzcv_q;
    if (flags_load)       nzcv_d = flags_wdata;
    else if (flags_valid) nzcv_d = {negative_in, zero_in, carry_in, overflow_in};
  end

  // Condition codes come in true/inverse pairs: evaluate the even member, xor with cond[0].
  // Pair 7 (AL/NV) has base 1 so AL=1, NV=0. Uses forwarded flags.
  always_comb begin
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv_d;
    base = 1'b0;
    unique case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
    cond_hit = base ^ cond[0];
  end

  assign ovf_evt = flags_valid & overflow_in & ~flags_load;

  // Architectural flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nzcv_q <= RST_FLAGS;
    else        nzcv_q <= nzcv_d;
  end

  // Registered condition result: one pulse per request, dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_valid <= 1'b0;
      cond_true  <= 1'b0;
    end else begin
      cond_valid <= cond_req;
      cond_true  <= cond_req & cond_hit;
    end
  end

  // Saturating overflow counter; a clear coincident with an event keeps that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (ovf_clr)                    cnt_q <= ovf_evt ? CNT_W'(1) : '0;
    else if (ovf_evt && cnt_q != '1)     cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef STICKY_OVF_EN
  logic sticky_q;
  // Sticky overflow: set by any counted event, cleared only by ovf_clr (event wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sticky_q <= 1'b0;
    else if (ovf_evt) sticky_q <= 1'b1;
    else if (ovf_clr) sticky_q <= 1'b0;
  end
  assign sticky_v = sticky_q;
`else
  assign sticky_v = 1'b0;
`endif

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_registro_banderas.sv
// Bench for registro_banderas: vector table, corner sequences, random run vs. reference model.
module tb_registro_banderas;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic flags_valid, carry_in, overflow_in, negative_in, zero_in;
  logic flags_load, cond_req, ovf_clr;
  logic [3:0] flags_wdata, cond;
  logic flag_n, flag_z, flag_c, flag_v, cond_valid, cond_true, sticky_v;
  logic [CNT_W-1:0] ovf_count;

  always #5 clk = ~clk;

  registro_banderas #(.CNT_W(CNT_W), .RST_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .flags_valid(flags_valid), .carry_in(carry_in),
    .overflow_in(overflow_in), .negative_in(negative_in), .zero_in(zero_in),
    .flags_load(flags_load), .flags_wdata(flags_wdata), .cond_req(cond_req),
    .cond(cond), .ovf_clr(ovf_clr), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .cond_valid(cond_valid),
    .cond_true(cond_true), .ovf_count(ovf_count), .sticky_v(sticky_v));

  int errors = 0, checks = 0;

  // reference model state
  logic [3:0] m_nzcv;
  int         m_cnt;
  logic       m_sticky, m_cv, m_ct;

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_nzcv = 4'b0000; m_cnt = 0; m_sticky = 1'b0; m_cv = 1'b0; m_ct = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nxt;
    bit evt;
    nxt = flags_load ? flags_wdata :
          flags_valid ? {negative_in, zero_in, carry_in, overflow_in} : m_nzcv;
    evt = flags_valid && overflow_in && !flags_load;
    m_cv = cond_req;
    m_ct = cond_req ? ref_cond(cond, nxt) : 1'b0;
    m_nzcv = nxt;
    if (ovf_clr) m_cnt = evt ? 1 : 0;
    else if (evt && m_cnt < CMAX) m_cnt++;
    if (STICKY) begin
      if (evt) m_sticky = 1'b1;
      else if (ovf_clr) m_sticky = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(m_nzcv));
    chk({tag, ".cond_valid"}, 32'(cond_valid), 32'(m_cv));
    if (m_cv) chk({tag, ".cond_true"}, 32'(cond_true), 32'(m_ct));
    chk({tag, ".ovf_count"}, 32'(ovf_count), 32'(m_cnt));
    chk({tag, ".sticky_v"}, 32'(sticky_v), 32'(m_sticky));
  endtask

  task automatic idle();
    flags_valid = 0; carry_in = 0; overflow_in = 0; negative_in = 0; zero_in = 0;
    flags_load = 0; flags_wdata = 4'h0; cond_req = 0; cond = 4'h0; ovf_clr = 0;
  endtask

  // one clock: model follows the DUT from the inputs present at the edge
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
  endtask

  typedef struct {
    logic       load;
    logic [3:0] wdata;
    logic       valid;
    logic [3:0] fin;     // {N,Z,C,V} from ALU
    logic       req;
    logic [3:0] cc;
    logic [3:0] e_nzcv;
    logic       e_cv;
    logic       e_ct;
  } vec_t;

  vec_t tv[17];

  initial begin
    tv[0]  = '{1'b0, 4'h0, 1'b1, 4'b0110, 1'b1, 4'h0, 4'b0110, 1'b1, 1'b1}; // EQ, forwarded
    tv[1]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h8, 4'b0110, 1'b1, 1'b0}; // HI
    tv[2]  = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 4'hA, 4'b1001, 1'b1, 1'b1}; // GE
    tv[3]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'hB, 4'b1001, 1'b1, 1'b0}; // LT
    tv[4]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'hC, 4'b1001, 1'b1, 1'b1}; // GT
    tv[5]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'hD, 4'b1001, 1'b1, 1'b0}; // LE
    tv[6]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'hF, 4'b1001, 1'b1, 1'b0}; // NV
    tv[7]  = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'hE, 4'b1001, 1'b1, 1'b1}; // AL
    tv[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0}; // load beats valid
    tv[9]  = '{1'b0, 4'h0, 1'b1, 4'b1010, 1'b1, 4'h9, 4'b1010, 1'b1, 1'b0}; // LS
    tv[10] = '{1'b0, 4'h0, 1'b1, 4'b0100, 1'b1, 4'h1, 4'b0100, 1'b1, 1'b0}; // NE
    tv[11] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h3, 4'b0100, 1'b1, 1'b1}; // CC
    tv[12] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h4, 4'b0100, 1'b1, 1'b0}; // MI
    tv[13] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h5, 4'b0100, 1'b1, 1'b1}; // PL
    tv[14] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h6, 4'b0100, 1'b1, 1'b0}; // VS
    tv[15] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h7, 4'b0100, 1'b1, 1'b1}; // VC
    tv[16] = '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h2, 4'b0100, 1'b1, 1'b0}; // CS

    idle();
    model_reset();
    #12;
    chk("rst.nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'h0);
    chk("rst.cond_valid", 32'(cond_valid), 32'h0);
    chk("rst.cond_true", 32'(cond_true), 32'h0);
    chk("rst.ovf_count", 32'(ovf_count), 32'h0);
    chk("rst.sticky_v", 32'(sticky_v), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 17; i++) begin
      idle();
      flags_load = tv[i].load; flags_wdata = tv[i].wdata; flags_valid = tv[i].valid;
      {negative_in, zero_in, carry_in, overflow_in} = tv[i].fin;
      cond_req = tv[i].req; cond = tv[i].cc;
      cycle();
      chk($sformatf("vec%0d.nzcv", i), 32'({flag_n, flag_z, flag_c, flag_v}), 32'(tv[i].e_nzcv));
      chk($sformatf("vec%0d.cond_valid", i), 32'(cond_valid), 32'(tv[i].e_cv));
      if (tv[i].e_cv) chk($sformatf("vec%0d.cond_true", i), 32'(cond_true), 32'(tv[i].e_ct));
      check_model($sformatf("vec%0d", i));
    end
    chk("prio.ovf_count", 32'(ovf_count), 32'h0);

    // reset while a result is pending
    idle();
    flags_load = 1'b1; flags_wdata = 4'b1111; cond_req = 1'b1; cond = 4'h0;
    cycle();
    chk("midrst.pre_valid", 32'(cond_valid), 32'h1);
    chk("midrst.pre_true", 32'(cond_true), 32'h1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'h0);
    chk("midrst.cond_valid", 32'(cond_valid), 32'h0);
    chk("midrst.ovf_count", 32'(ovf_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("midrst.no_pulse", 32'(cond_valid), 32'h0);

    // saturation
    for (int i = 0; i < 300; i++) begin
      idle();
      flags_valid = 1'b1;
      {negative_in, zero_in, carry_in, overflow_in} = 4'($urandom_range(0, 15)) | 4'b0001;
      cycle();
      check_model("sat");
    end
    chk("sat.ovf_count", 32'(ovf_count), 32'(CMAX));
    chk("sat.sticky_v", 32'(sticky_v), 32'(STICKY));
    idle(); flags_valid = 1'b1; overflow_in = 1'b1; ovf_clr = 1'b1;
    cycle();
    chk("clr_evt.ovf_count", 32'(ovf_count), 32'h1);
    chk("clr_evt.sticky_v", 32'(sticky_v), 32'(STICKY));
    idle(); ovf_clr = 1'b1;
    cycle();
    chk("clr.ovf_count", 32'(ovf_count), 32'h0);
    chk("clr.sticky_v", 32'(sticky_v), 32'h0);

    // sticky hold
    idle(); flags_valid = 1'b1; overflow_in = 1'b1;
    cycle();
    chk("sticky.set", 32'(sticky_v), 32'(STICKY));
    for (int i = 0; i < 10; i++) begin
      idle(); flags_valid = 1'b1; carry_in = i[0]; zero_in = i[1];
      cycle();
      chk($sformatf("sticky.hold%0d", i), 32'(sticky_v), 32'(STICKY));
    end
    idle(); ovf_clr = 1'b1;
    cycle();
    chk("sticky.clr", 32'(sticky_v), 32'h0);
    check_model("sticky");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      flags_load  = ($urandom_range(0, 7) == 0);
      flags_wdata = 4'($urandom_range(0, 15));
      flags_valid = $urandom_range(0, 1) == 1;
      {negative_in, zero_in, carry_in, overflow_in} = 4'($urandom_range(0, 15));
      cond_req    = $urandom_range(0, 1) == 1;
      cond        = 4'($urandom_range(0, 15));
      ovf_clr     = ($urandom_range(0, 31) == 0);
      cycle();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/registro_banderas.md
Name: registro_banderas

Overview:
- Status-flag register sitting directly downstream of the ALU flag generator.
- Captures Carry/Overflow/Negative/Zero per valid ALU operation and holds them as architectural NZCV state.
- Evaluates 4-bit condition codes against that state for branch/select logic, one cycle later.
- Keeps a saturating count of overflow events for debug readout.

Parameters:
- CNT_W, 8, width of overflow event counter.
- RST_FLAGS, 4'b0000, reset value of {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flags_valid  input  1  ALU result valid this cycle; capture flag inputs.
- carry_in  input  1  Carry from ALU flag stage.
- overflow_in  input  1  Overflow from ALU flag stage.
- negative_in  input  1  Negative from ALU flag stage.
- zero_in  input  1  Zero from ALU flag stage.
- flags_load  input  1  direct write of NZCV (context restore).
- flags_wdata  input  4  {N,Z,C,V} value for flags_load.
- cond_req  input  1  request condition evaluation.
- cond  input  4  condition code.
- ovf_clr  input  1  clear overflow counter (and sticky flag).
- flag_n  output  1  registered Negative.
- flag_z  output  1  registered Zero.
- flag_c  output  1  registered Carry.
- flag_v  output  1  registered Overflow.
- cond_valid  output  1  one-cycle pulse: cond_true valid.
- cond_true  output  1  evaluation result.
- ovf_count  output  CNT_W  saturating overflow event count.
- sticky_v  output  1  sticky overflow (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): {flag_n,flag_z,flag_c,flag_v}=RST_FLAGS; cond_valid=0; cond_true=0; ovf_count=0; sticky_v=0. Reset mid-evaluation drops the pending result; no pulse after release.
- Flag update at posedge:
  - flags_load=1: NZCV<=flags_wdata. Has priority over flags_valid.
  - else flags_valid=1: NZCV<={negative_in,zero_in,carry_in,overflow_in}.
  - else hold.
- Condition evaluation: cond_req sampled at posedge t; cond_valid=1 and cond_true registered during cycle t+1. Back-to-back requests give back-to-back pulses.
- Forwarding: evaluation uses the next-state NZCV, i.e. the value being written in the same cycle (load or valid). A request coincident with an update sees the new flags.
- Condition table (cond -> true when):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C;
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V;
  - 8 HI C&!Z; 9 LS !C|Z;
  - A GE N==V; B LT N!=V;
  - C GT !Z&(N==V); D LE Z|(N!=V);
  - E AL 1; F NV 0.
- Overflow counter:
  - Increments when flags_valid=1 & overflow_in=1 & flags_load=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - ovf_clr has priority: count<=0. Simultaneous clr+increment gives 1 (the event is not lost).
  - flags_load never changes the count.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro STICKY_OVF_EN.
- Defined:
  - sticky_v sets on any counted overflow event and holds until ovf_clr.
  - Simultaneous clr and event leaves sticky_v=1.
  - Reset clears sticky_v.
- Undefined: sticky_v is tied to 0 and no register is inferred.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> NZCV=0000, ovf_count=0, cond_valid=0 immediately; no pulse after release.
- Update/eval: flags_valid=1 with n=0,z=1,c=1,v=0 plus cond_req with cond=0 (EQ) in the same cycle -> next cycle NZCV=0110, cond_valid=1, cond_true=1. Then cond=8 (HI) -> cond_true=0.
- Signed conditions: flags_load=1, wdata=1001 (N=1,V=1) -> GE(A)=1, LT(B)=0, GT(C)=1, LE(D)=0. NV(F) always 0; AL(E) always 1.
- Priority: flags_load=1 (wdata=0000) with flags_valid=1 and overflow_in=1 -> NZCV=0000, ovf_count unchanged.
- Saturation: with CNT_W=8, 300 overflow events -> ovf_count=255. ovf_clr together with an event -> ovf_count=1.
- Sticky (STICKY_OVF_EN defined): one overflow -> sticky_v=1; it holds through 10 non-overflow ops and clears on ovf_clr. With the macro undefined, sticky_v stays 0 throughout.
